// File: rtl/mult_seq_16_pkg.sv
// Shared definitions for the iterative 16x16 shift-and-add multiplier:
// FSM state encoding, operand width, iteration count and the magnitude helper.
package mult_seq_16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The iteration adder is a fixed 16-bit part, so the width cannot change.
  localparam int WIDTH = 16;
  localparam int ITER  = 16;

  // Absolute value of a 16-bit operand when it is two's complement.
  // 0x8000 maps to 0x8000, which is the correct unsigned magnitude.
  function automatic logic [15:0] magnitude(input logic [15:0] v, input logic sgn);
    return (sgn && v[15]) ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/mult_seq_16_cla.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups chained by
// their group carries. Provides sum, carry-out and a signed/unsigned
// overflow indication.
module mult_seq_16_cla
  import mult_seq_16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        sign,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ofl
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  // Carries c1..c4 of one 4-bit group computed directly from g/p and the group carry-in.
  function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp, input logic ci);
    logic [3:0] co;
    co[0] = gg[0] | (pp[0] & ci);
    co[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    co[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    co[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return co;
  endfunction

  // Generate/propagate, group lookahead carries, then sum and flags.
  always_comb begin
    g       = a & b;
    p       = a ^ b;
    c       = '0;
    c[0]    = cin;
    c[4:1]  = cla4(g[3:0],   p[3:0],   c[0]);
    c[8:5]  = cla4(g[7:4],   p[7:4],   c[4]);
    c[12:9] = cla4(g[11:8],  p[11:8],  c[8]);
    c[16:13]= cla4(g[15:12], p[15:12], c[12]);
    sum     = p ^ c[15:0];
    cout    = c[16];
    ofl     = sign ? ((a[15] == b[15]) && (sum[15] != a[15])) : c[16];
  end

endmodule

// File: rtl/mult_seq_16.sv
// Iterative shift-and-add 16x16 multiplier with start/busy/done handshake.
// Operands are converted to magnitudes, multiplied over 16 add/shift
// iterations, and the sign is reapplied in a final FIX cycle.
// Fixed latency: start accepted at edge T gives done in cycle T+18.
module mult_seq_16
  import mult_seq_16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ofl
);

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [15:0] mcand;
  logic [15:0] mq;
  logic [15:0] acc;
  logic        neg;
  logic        op_signed;

  logic [15:0] add_sum;
  logic        add_cout;
  logic        unused_adder_ofl;

  logic [15:0] step_s;
  logic        step_c;
  logic [31:0] p_raw;
  logic [31:0] p_fix;
  logic        ofl_fix;

  // Iteration adder: unsigned, no carry-in; only sum and carry-out matter.
  mult_seq_16_cla u_cla (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sign (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .ofl  (unused_adder_ofl)
  );

  // Per-iteration partial sum and the sign-corrected final product with its overflow flag.
  always_comb begin
    step_c  = mq[0] ? add_cout : 1'b0;
    step_s  = mq[0] ? add_sum  : acc;
    p_raw   = {acc, mq};
    p_fix   = neg ? (~p_raw + 32'd1) : p_raw;
    ofl_fix = op_signed ? (p_fix[31:16] != {16{p_fix[15]}})
                        : (p_fix[31:16] != 16'd0);
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
      ofl       <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mq        <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      op_signed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand     <= magnitude(a, sign);
            mq        <= magnitude(b, sign);
            acc       <= '0;
            cnt       <= '0;
            neg       <= sign & (a[15] ^ b[15]);
            op_signed <= sign;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // 33-bit {carry, sum, mq} shifted right by one keeps the carry.
          acc <= {step_c, step_s[15:1]};
          mq  <= {step_s[0], mq[15:1]};
          cnt <= cnt + 5'd1;
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          product <= p_fix;
          ofl     <= ofl_fix;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_16.sv
// Self-checking bench for mult_seq_16: expected results are queued when an
// operation is started and popped when done is observed.
module tb_mult_seq_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sign = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ofl;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] p;
    logic        o;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mult_seq_16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .sign    (sign),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ofl     (ofl)
  );

  // Reference product and overflow computed with native arithmetic.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic ms, input string nm);
    exp_t e;
    logic signed [15:0] sa;
    logic signed [15:0] sbv;
    logic signed [31:0] sr;
    sa  = ma;
    sbv = mb;
    if (ms) begin
      sr  = sa * sbv;
      e.p = sr;
      e.o = (e.p[31:16] != {16{e.p[15]}});
    end else begin
      e.p = {16'd0, ma} * {16'd0, mb};
      e.o = (e.p[31:16] != 16'd0);
    end
    e.name = nm;
    return e;
  endfunction

  // Drive one start pulse (caller is at posedge+1 with the DUT in IDLE) and queue its expectation.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                       input logic [31:0] ep, input logic eo, input string nm);
    exp_t e;
    a = ia;
    b = ib;
    sign = is;
    start = 1'b1;
    e.p = ep;
    e.o = eo;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called just after the accepting edge (cycle 1); returns the cycle done was seen and busy behaviour.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        lat = c;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (product !== 32'h0) begin fails++; $display("FAIL reset_product got %h want 00000000", product); end
    tests++; if (ofl !== 1'b0) begin fails++; $display("FAIL reset_ofl got %b want 0", ofl); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset: busy=%b done=%b product=%h ofl=%b", busy, done, product, ofl);
  endtask

  task automatic test_products();
    logic [15:0] ta [7] = '{16'h0003, 16'hFFFF, 16'h0100, 16'hFFFD, 16'hFFFF, 16'h8000, 16'h0000};
    logic [15:0] tb [7] = '{16'h0005, 16'hFFFF, 16'h0100, 16'h0007, 16'hFFFF, 16'h8000, 16'hFFFB};
    logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] tp [7] = '{32'h0000000F, 32'hFFFE0001, 32'h00010000, 32'hFFFFFFEB,
                            32'h00000001, 32'h40000000, 32'h00000000};
    logic        to [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      logic [15:0] xa;
      logic [15:0] xb;
      logic        xs;
      exp_t        e;
      int          lat;
      bit          bok;
      logic [31:0] held;
      if (i < 7) begin
        xa = ta[i]; xb = tb[i]; xs = ts[i];
        e.p = tp[i]; e.o = to[i]; e.name = $sformatf("plan%0d", i);
      end else begin
        xa = 16'($urandom); xb = 16'($urandom); xs = 1'($urandom_range(0, 1));
        e = model(xa, xb, xs, $sformatf("rand%0d", i));
      end
      issue(xa, xb, xs, e.p, e.o, e.name);
      wait_done(lat, bok);
      tests++; if (lat !== 18) begin fails++; $display("FAIL %s latency got %0d want 18", e.name, lat); end
      tests++; if (!bok) begin fails++; $display("FAIL %s busy_window got bad want high T+1..T+17 only", e.name); end
      if (sb.size() == 0) begin
        tests++; fails++; $display("FAIL %s scoreboard got empty want entry", e.name);
      end else begin
        e = sb.pop_front();
        tests++; if (product !== e.p) begin fails++; $display("FAIL %s product got %h want %h", e.name, product, e.p); end
        tests++; if (ofl !== e.o) begin fails++; $display("FAIL %s ofl got %b want %b", e.name, ofl, e.o); end
      end
      $display("[TB] %s a=%h b=%h sign=%b -> product=%h ofl=%b lat=%0d", e.name, xa, xb, xs, product, ofl, lat);
      held = product;
      @(posedge clk);
      #1;
      tests++; if (product !== held || done !== 1'b0) begin
        fails++; $display("FAIL %s hold got product=%h done=%b want product=%h done=0", e.name, product, done, held);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    e = model(16'h1234, 16'h0056, 1'b0, "ignore");
    issue(16'h1234, 16'h0056, 1'b0, e.p, e.o, e.name);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (c == 5 || c == 17) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sign = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    tests++; if (lat !== 18) begin fails++; $display("FAIL ignore latency got %0d want 18", lat); end
    e = sb.pop_front();
    tests++; if (product !== e.p) begin fails++; $display("FAIL ignore product got %h want %h", product, e.p); end
    tests++; if (ofl !== e.o) begin fails++; $display("FAIL ignore ofl got %b want %b", ofl, e.o); end
    $display("[TB] ignore: product=%h ofl=%b lat=%0d", product, ofl, lat);
    @(posedge clk);
    #1;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL ignore_no_extra got done=%b busy=%b want 0 0", done, busy);
    end
    // Start in the cycle right after done must be accepted.
    issue(16'h0011, 16'h0003, 1'b0, 32'h00000033, 1'b0, "after_done");
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL after_done_accept got busy=%b want 1", busy); end
    begin
      bit bok;
      wait_done(lat, bok);
    end
    e = sb.pop_front();
    tests++; if (lat !== 18 || product !== e.p) begin
      fails++; $display("FAIL after_done got lat=%0d product=%h want 18 %h", lat, product, e.p);
    end
    $display("[TB] after_done: product=%h lat=%0d", product, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    bit   bok;
    bit   saw_done;
    issue(16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 1'b0, "aborted");
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      fails++; $display("FAIL abort_clear got busy=%b done=%b product=%h want 0 0 00000000", busy, done, product);
    end
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    tests++; if (saw_done) begin fails++; $display("FAIL abort_no_done got done pulse want none"); end
    $display("[TB] abort: busy=%b done=%b product=%h", busy, done, product);
    issue(16'h0007, 16'h0009, 1'b0, 32'h0000003F, 1'b0, "post_reset");
    wait_done(lat, bok);
    e = sb.pop_front();
    tests++; if (lat !== 18 || !bok || product !== e.p || ofl !== e.o) begin
      fails++; $display("FAIL post_reset got lat=%0d product=%h ofl=%b want 18 %h %b", lat, product, ofl, e.p, e.o);
    end
    $display("[TB] post_reset: product=%h lat=%0d", product, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   bok;
    a = 16'h0002; b = 16'h0002; sign = 1'b0; start = 1'b1;
    e.p = 32'h00000004; e.o = 1'b0; e.name = "held_first";
    sb.push_back(e);
    @(posedge clk);
    #1;
    wait_done(lat, bok);
    e = sb.pop_front();
    tests++; if (lat !== 18 || product !== e.p) begin
      fails++; $display("FAIL held_first got lat=%0d product=%h want 18 %h", lat, product, e.p);
    end
    $display("[TB] held_first: product=%h lat=%0d", product, lat);
    a = 16'h0003;
    e.p = 32'h00000006; e.o = 1'b0; e.name = "held_second";
    sb.push_back(e);
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_not_in_done got busy=%b want 0", busy); end
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL held_accept_idle got busy=%b want 1", busy); end
    wait_done(lat, bok);
    e = sb.pop_front();
    tests++; if (lat !== 18 || product !== e.p) begin
      fails++; $display("FAIL held_second got lat=%0d product=%h want 18 %h", lat, product, e.p);
    end
    $display("[TB] held_second: product=%h lat=%0d", product, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_products();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_seq_16.md
Name: mult_seq_16

Overview:
- Iterative shift-and-add 16x16 multiplier in the execute stage, beside the ALU.
- Each iteration performs one 16-bit add on the team's existing 16-bit carry-lookahead adder and uses its carry-out.
- Produces a 32-bit product and a 16-bit-result overflow flag.
- Operates under a start/busy/done handshake, so the pipeline stalls while it runs.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported because the adder is fixed at 16 bits.
- ITER, 16, number of add/shift iterations. Must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request. Sampled only in IDLE.
- a  in  16  multiplicand
- b  in  16  multiplier
- sign  in  1  1 = two's-complement operands, 0 = unsigned
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when product is valid
- product  out  32  result. Held from done until the next accepted start.
- ofl  out  1  result does not fit in 16 bits. Valid with product.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, product=0, ofl=0, counter=0.
  - Reset asserted mid-operation aborts the operation. No done is ever produced for the aborted request.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE, on start=1 at edge T:
  - Latch mcand=|a| and mq=|b|. Magnitudes apply only when sign=1; unsigned operands pass through.
  - 0x8000 has magnitude 0x8000. It fits unsigned, no special case.
  - acc=0, cnt=0.
  - neg = sign & (a[15]^b[15]).
  - Go to RUN. busy=1 from T+1.
- RUN, per cycle:
  - If mq[0]=1: {c,s} = acc + mcand via the adder. Otherwise {c,s} = {0,acc}.
  - {acc,mq} <= {c,s,mq} >> 1 (33-bit concatenation, logical shift).
  - cnt++. After 16 RUN cycles (cnt reaches 15 and is processed), go to FIX.
- FIX, one cycle:
  - p={acc,mq}.
  - product <= neg ? (~p + 1) : p, as a 32-bit negate. A zero product stays 0.
  - ofl <= sign ? (product[31:16] != {16{product[15]}}) : (product[31:16] != 0), evaluated on the value being written.
- DONE, one cycle: done=1, busy=0. Next state IDLE.
- Latency: start accepted at edge T gives done=1 in cycle T+18. It is fixed and independent of operand values.
- A start seen outside IDLE is ignored. It is neither queued nor an error.
  - start held high through DONE is not accepted until IDLE. The earliest back-to-back start is accepted the cycle after done.
- a, b and sign are sampled only at acceptance. Changes while busy have no effect.
- product and ofl hold their last value in IDLE. done is never high in the same cycle as busy.
- Arithmetic:
  - All internal adds are 16-bit with carry-out.
  - The 33-bit shift keeps the carry, so the unsigned product is exact for 0xFFFF*0xFFFF.
  - Signed product is exact for all inputs, including 0x8000*0x8000.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3) and ITER.
- One sub-module: the existing 16-bit carry-lookahead adder for the iteration add.
  - Cin=0, sign=0.
  - Its OFL output is left unused; only Sum and Cout are used.
- The FIX negate and the magnitude conversion are inline logic, not separate modules.

Test Plan:
- Unsigned 3*5 (a=0x0003, b=0x0005, sign=0) -> product=0x0000000F, ofl=0. done exactly 18 cycles after the start edge. busy high for cycles T+1..T+17.
- Unsigned 0xFFFF*0xFFFF -> product=0xFFFE0001, ofl=1. Signed 0x0100*0x0100 -> product=0x00010000, ofl=1.
- Signed -3*7 (0xFFFD, 0x0007) -> product=0xFFFFFFEB, ofl=0. Signed -1*-1 -> 0x00000001, ofl=0. Signed 0x8000*0x8000 -> 0x40000000, ofl=1. Signed 0*(-5) -> 0x00000000, ofl=0.
- Start pulses at T+5 and T+17 during a busy operation, with a and b changed -> ignored. Single done with the original result. A new start the cycle after done is accepted.
- rst_n low at T+8 mid-RUN -> busy, done and product go to 0 immediately. No done pulse. A start after release -> normal result 18 cycles later.
- Start held high continuously with 2*2 -> product=0x00000004 at the first done. The second operation is accepted in IDLE the cycle after DONE.
